// File: rtl/axi4_line_en_sram_rmw_bridge_if.sv
// ============================================================================
//  Module      : axi4_if / generic_sram_line_en_if
//  Description : Bus bundles for the AXI4 line-enable SRAM bridge.
//                axi4_if                 - full AXI4 channel set (AW/W/B/AR/R)
//                                          modports: master (initiator side),
//                                          slave (bridge side)
//                generic_sram_line_en_if - line-wide SRAM port with single
//                                          read/write enables, 1-cycle read
//                                          modports: sram_client (bridge
//                                          side), sram (memory side)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface axi4_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 1024,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

interface generic_sram_line_en_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 1024
);
    logic [ADDR_W-1:0] addr;
    logic              read_en;
    logic              write_en;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport sram_client (
        output addr, read_en, write_en, write_data,
        input  read_data
    );

    modport sram (
        input  addr, read_en, write_en, write_data,
        output read_data
    );
endinterface

`default_nettype wire

// File: rtl/axi4_line_en_sram_rmw_bridge.sv
// ============================================================================
//  Module      : axi4_line_en_sram_rmw_bridge
//  Description : AXI4 slave driving a line-enable SRAM. Every beat is one full
//                line. Partial-strobe write beats are merged with the stored
//                line through an internal read-modify-write when the macro
//                AXI4_LINE_EN_BRIDGE_RMW_EN is defined; otherwise they are
//                dropped and the burst answers SLVERR.
//  Ports       : clk      - single rising-edge clock
//                rst      - synchronous active-high reset
//                axi_if   - axi4_if.slave (AW/W/B/AR/R channels)
//                sram_if  - generic_sram_line_en_if.sram_client
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi4_line_en_sram_rmw_bridge #(
    parameter int MEM_ADDR_BITS     = 10,
    parameter int AXI_ADDRESS_WIDTH = 32,
    parameter int AXI_DATA_WIDTH    = 1024,
    parameter int AXI_ID_WIDTH      = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    axi4_if.slave                        axi_if,
    generic_sram_line_en_if.sram_client  sram_if
);

    localparam int c_STRB_W = AXI_DATA_WIDTH / 8;
    localparam int c_OFFS   = $clog2(c_STRB_W);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_RD_REQ  = 3'd1;
    localparam logic [2:0] c_S_RD_DATA = 3'd2;
    localparam logic [2:0] c_S_WR_DATA = 3'd3;
`ifdef AXI4_LINE_EN_BRIDGE_RMW_EN
    localparam logic [2:0] c_S_RMW_RD  = 3'd4;
    localparam logic [2:0] c_S_RMW_WR  = 3'd5;
`endif
    localparam logic [2:0] c_S_WR_RESP = 3'd6;

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic                      r_in_rst;
    logic                      r_rr_rd;     // 1: read wins the next contested pick
    logic                      r_err;
    logic                      r_rd_hold;   // RDATA now comes from r_rdata
    logic [MEM_ADDR_BITS-1:0]  r_idx;
    logic [7:0]                r_len;
    logic [1:0]                r_burst;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [7:0]                r_beat;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;

    logic                      w_ar_sel;
    logic                      w_aw_sel;
    logic                      w_ar_go;
    logic                      w_aw_go;
    logic                      w_last_beat;
    logic                      w_w_last;
    logic                      w_strb_full;
    logic                      w_strb_part;
    logic [MEM_ADDR_BITS-1:0]  w_idx_nxt;
    logic [MEM_ADDR_BITS-1:0]  w_ar_line;
    logic [MEM_ADDR_BITS-1:0]  w_aw_line;
    logic                      w_unused_ok;

    // Low address bits select a byte inside a line, upper bits beyond the
    // SRAM depth are dropped (addresses wrap modulo depth); AxSIZE is ignored.
    assign w_unused_ok = ^{axi_if.araddr, axi_if.awaddr, axi_if.arsize, axi_if.awsize};

    assign w_ar_line = MEM_ADDR_BITS'(axi_if.araddr >> c_OFFS);
    assign w_aw_line = MEM_ADDR_BITS'(axi_if.awaddr >> c_OFFS);

    // Exactly one channel is offered ready when both request at once.
    assign w_ar_sel = axi_if.arvalid && (!axi_if.awvalid || r_rr_rd);
    assign w_aw_sel = axi_if.awvalid && !(axi_if.arvalid && r_rr_rd);
    assign w_ar_go  = (r_state == c_S_IDLE) && !r_in_rst && w_ar_sel;
    assign w_aw_go  = (r_state == c_S_IDLE) && !r_in_rst && w_aw_sel;

    assign w_last_beat = (r_beat == r_len);
    assign w_w_last    = axi_if.wlast || w_last_beat;
    assign w_strb_full = &axi_if.wstrb;
    assign w_strb_part = !w_strb_full && (|axi_if.wstrb);

    function automatic logic [MEM_ADDR_BITS-1:0] f_next_idx(
        input logic [MEM_ADDR_BITS-1:0] idx,
        input logic [7:0]               len,
        input logic [1:0]               burst
    );
        logic [MEM_ADDR_BITS-1:0] w_inc;
        logic [MEM_ADDR_BITS-1:0] w_mask;
        w_inc  = idx + MEM_ADDR_BITS'(1);
        w_mask = MEM_ADDR_BITS'(len[3:0]);
        case (burst)
            2'b00:   return idx;
            2'b10: begin
                // Power-of-two windows only; other lengths fall back to INCR.
                if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                    return (idx & ~w_mask) | (w_inc & w_mask);
                else
                    return w_inc;
            end
            default: return w_inc;
        endcase
    endfunction

    assign w_idx_nxt = f_next_idx(r_idx, r_len, r_burst);

`ifdef AXI4_LINE_EN_BRIDGE_RMW_EN
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [c_STRB_W-1:0]       r_wstrb;
    logic                      r_wlast_q;
    logic [AXI_DATA_WIDTH-1:0] w_bmask;
    logic [AXI_DATA_WIDTH-1:0] w_merged;

    for (genvar gi = 0; gi < c_STRB_W; gi++) begin : g_byte_mask
        assign w_bmask[gi*8 +: 8] = {8{r_wstrb[gi]}};
    end

    assign w_merged = (r_wdata & w_bmask) | (sram_if.read_data & ~w_bmask);
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_ar_go)      w_state_nxt = c_S_RD_REQ;
                else if (w_aw_go) w_state_nxt = c_S_WR_DATA;
            end
            c_S_RD_REQ:  w_state_nxt = c_S_RD_DATA;
            c_S_RD_DATA: begin
                if (axi_if.rready) w_state_nxt = w_last_beat ? c_S_IDLE : c_S_RD_REQ;
            end
            c_S_WR_DATA: begin
                if (axi_if.wvalid) begin
`ifdef AXI4_LINE_EN_BRIDGE_RMW_EN
                    if (w_strb_part)   w_state_nxt = c_S_RMW_RD;
                    else if (w_w_last) w_state_nxt = c_S_WR_RESP;
`else
                    if (w_w_last)      w_state_nxt = c_S_WR_RESP;
`endif
                end
            end
`ifdef AXI4_LINE_EN_BRIDGE_RMW_EN
            c_S_RMW_RD:  w_state_nxt = c_S_RMW_WR;
            c_S_RMW_WR:  w_state_nxt = r_wlast_q ? c_S_WR_RESP : c_S_WR_DATA;
`endif
            c_S_WR_RESP: begin
                if (axi_if.bready) w_state_nxt = c_S_IDLE;
            end
            default:     w_state_nxt = c_S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        axi_if.arready     = 1'b0;
        axi_if.awready     = 1'b0;
        axi_if.wready      = 1'b0;
        axi_if.rvalid      = 1'b0;
        axi_if.rdata       = '0;
        axi_if.rlast       = 1'b0;
        axi_if.rresp       = 2'b00;
        axi_if.rid         = r_id;
        axi_if.bvalid      = 1'b0;
        axi_if.bresp       = 2'b00;
        axi_if.bid         = r_id;
        sram_if.addr       = r_idx;
        sram_if.read_en    = 1'b0;
        sram_if.write_en   = 1'b0;
        sram_if.write_data = axi_if.wdata;
        case (r_state)
            c_S_IDLE: begin
                axi_if.arready = !r_in_rst && !w_aw_sel;
                axi_if.awready = !r_in_rst && !w_ar_sel;
            end
            c_S_RD_REQ:  sram_if.read_en = 1'b1;
            c_S_RD_DATA: begin
                axi_if.rvalid = 1'b1;
                axi_if.rdata  = r_rd_hold ? r_rdata : sram_if.read_data;
                axi_if.rlast  = w_last_beat;
            end
            c_S_WR_DATA: begin
                axi_if.wready    = 1'b1;
                sram_if.write_en = axi_if.wvalid && w_strb_full;
            end
`ifdef AXI4_LINE_EN_BRIDGE_RMW_EN
            c_S_RMW_RD:  sram_if.read_en = 1'b1;
            c_S_RMW_WR: begin
                sram_if.write_en   = 1'b1;
                sram_if.write_data = w_merged;
            end
`endif
            c_S_WR_RESP: begin
                axi_if.bvalid = 1'b1;
                axi_if.bresp  = r_err ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_rst  <= 1'b1;
            r_rr_rd   <= 1'b1;
            r_err     <= 1'b0;
            r_rd_hold <= 1'b0;
            r_idx     <= '0;
            r_len     <= '0;
            r_burst   <= '0;
            r_id      <= '0;
            r_beat    <= '0;
        end else begin
            r_in_rst <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_ar_go) begin
                        r_idx   <= w_ar_line;
                        r_len   <= axi_if.arlen;
                        r_burst <= axi_if.arburst;
                        r_id    <= axi_if.arid;
                        r_beat  <= '0;
                        r_rr_rd <= 1'b0;
                    end else if (w_aw_go) begin
                        r_idx   <= w_aw_line;
                        r_len   <= axi_if.awlen;
                        r_burst <= axi_if.awburst;
                        r_id    <= axi_if.awid;
                        r_beat  <= '0;
                        r_err   <= 1'b0;
                        r_rr_rd <= 1'b1;
                    end
                end
                c_S_RD_DATA: begin
                    // SRAM output is only guaranteed for one cycle; hold it.
                    if (!r_rd_hold) begin
                        r_rdata   <= sram_if.read_data;
                        r_rd_hold <= 1'b1;
                    end
                    if (axi_if.rready) begin
                        r_rd_hold <= 1'b0;
                        r_idx     <= w_idx_nxt;
                        r_beat    <= r_beat + 8'd1;
                    end
                end
                c_S_WR_DATA: begin
                    if (axi_if.wvalid) begin
                        if (w_strb_part) begin
`ifdef AXI4_LINE_EN_BRIDGE_RMW_EN
                            r_wdata   <= axi_if.wdata;
                            r_wstrb   <= axi_if.wstrb;
                            r_wlast_q <= w_w_last;
`else
                            r_err  <= 1'b1;
                            r_idx  <= w_idx_nxt;
                            r_beat <= r_beat + 8'd1;
`endif
                        end else begin
                            r_idx  <= w_idx_nxt;
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
`ifdef AXI4_LINE_EN_BRIDGE_RMW_EN
                c_S_RMW_WR: begin
                    r_idx  <= w_idx_nxt;
                    r_beat <= r_beat + 8'd1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi4_line_en_sram_rmw_bridge.sv
// ============================================================================
//  Module      : tb_axi4_line_en_sram_rmw_bridge
//  Description : Directed self-checking bench for the AXI4 line-enable SRAM
//                bridge, with a 1-cycle-latency line SRAM model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi4_line_en_sram_rmw_bridge;

    localparam int c_AW  = 32;
    localparam int c_DW  = 1024;
    localparam int c_IDW = 4;
    localparam int c_MAB = 10;
    localparam int c_LIM = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_if #(.ADDR_W(c_AW), .DATA_W(c_DW), .ID_W(c_IDW)) axi ();
    generic_sram_line_en_if #(.ADDR_W(c_MAB), .DATA_W(c_DW)) sram ();

    axi4_line_en_sram_rmw_bridge #(
        .MEM_ADDR_BITS(c_MAB), .AXI_ADDRESS_WIDTH(c_AW),
        .AXI_DATA_WIDTH(c_DW), .AXI_ID_WIDTH(c_IDW)
    ) u_dut (
        .clk(clk), .rst(rst), .axi_if(axi), .sram_if(sram)
    );

    // ---------------------------------------------------------- SRAM model
    logic [c_DW-1:0]  mem [0:(1<<c_MAB)-1];
    logic [c_DW-1:0]  rd_q;
    logic             bd_we = 1'b0;
    logic [c_MAB-1:0] bd_addr = '0;
    logic [c_DW-1:0]  bd_data = '0;

    always @(posedge clk) begin
        if (bd_we)              mem[bd_addr]   <= bd_data;
        else if (sram.write_en) mem[sram.addr] <= sram.write_data;
        if (sram.read_en)       rd_q <= mem[sram.addr];
    end
    assign sram.read_data = rd_q;

    // ------------------------------------------------------------ monitors
    logic     both_seen = 1'b0;
    logic     log_en = 1'b0;
    int       gcnt = 0;
    logic     glog [0:15];
    always @(posedge clk) begin
        if (sram.read_en && sram.write_en) both_seen <= 1'b1;
        if (log_en && gcnt < 16) begin
            if (axi.arvalid && axi.arready) begin glog[gcnt] <= 1'b0; gcnt <= gcnt + 1; end
            else if (axi.awvalid && axi.awready) begin glog[gcnt] <= 1'b1; gcnt <= gcnt + 1; end
        end
    end

    // ------------------------------------------------------------ checking
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [c_DW-1:0] got, input logic [c_DW-1:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got ..%h expected ..%h", tag, got[191:0], exp[191:0]);
        else
            n_pass++;
    endtask

    function automatic logic [c_DW-1:0] pat(input int n);
        return {32{32'hC0DE0000 + 32'(n)}};
    endfunction

    function automatic logic [c_DW-1:0] wpat(input int n);
        return {32{32'hDA7A0000 + 32'(n)}};
    endfunction

    function automatic logic [c_AW-1:0] line_addr(input int line);
        return 32'(line) << 7;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bd_write(input int line, input logic [c_DW-1:0] d);
        bd_we = 1'b1; bd_addr = c_MAB'(line); bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic ar_send(input int line, input logic [7:0] len, input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        axi.araddr = line_addr(line); axi.arlen = len; axi.arburst = burst;
        axi.arid = id; axi.arsize = 3'd7; axi.arvalid = 1'b1;
        #1;
        while (!axi.arready && n < c_LIM) begin @(posedge clk); #2; n++; end
        if (n >= c_LIM) check("ar_timeout", 1, 0);
        tick();
        axi.arvalid = 1'b0;
    endtask

    task automatic aw_send(input int line, input logic [7:0] len, input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        axi.awaddr = line_addr(line); axi.awlen = len; axi.awburst = burst;
        axi.awid = id; axi.awsize = 3'd7; axi.awvalid = 1'b1;
        #1;
        while (!axi.awready && n < c_LIM) begin @(posedge clk); #2; n++; end
        if (n >= c_LIM) check("aw_timeout", 1, 0);
        tick();
        axi.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [c_DW-1:0] d, input logic [c_DW/8-1:0] s, input logic last);
        int n = 0;
        axi.wdata = d; axi.wstrb = s; axi.wlast = last; axi.wvalid = 1'b1;
        #1;
        while (!axi.wready && n < c_LIM) begin @(posedge clk); #2; n++; end
        if (n >= c_LIM) check("w_timeout", 1, 0);
        tick();
        axi.wvalid = 1'b0;
    endtask

    // Receives one R beat; RREADY stays low for 'hold' cycles while RDATA
    // must stay at the expected line.
    task automatic r_get(input string tag, input logic [c_DW-1:0] exp, input logic exp_last,
                         input logic [3:0] exp_id, input int hold);
        int n = 0;
        axi.rready = 1'b0;
        #1;
        while (!axi.rvalid && n < c_LIM) begin @(posedge clk); #2; n++; end
        if (n >= c_LIM) check({tag, "_timeout"}, 1, 0);
        check({tag, "_data"}, axi.rdata, exp);
        check({tag, "_last"}, c_DW'(axi.rlast), c_DW'(exp_last));
        check({tag, "_id"}, c_DW'(axi.rid), c_DW'(exp_id));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #2;
            check({tag, "_hold_valid"}, c_DW'(axi.rvalid), 1);
            check({tag, "_hold_data"}, axi.rdata, exp);
        end
        axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0;
    endtask

    task automatic b_get(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id);
        int n = 0;
        axi.bready = 1'b1;
        #1;
        while (!axi.bvalid && n < c_LIM) begin @(posedge clk); #2; n++; end
        if (n >= c_LIM) check({tag, "_timeout"}, 1, 0);
        check({tag, "_resp"}, c_DW'(axi.bresp), c_DW'(exp_resp));
        check({tag, "_id"}, c_DW'(axi.bid), c_DW'(exp_id));
        @(posedge clk); #1;
        axi.bready = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rvalid"}, c_DW'(axi.rvalid), 0);
        check({tag, "_bvalid"}, c_DW'(axi.bvalid), 0);
        check({tag, "_arready"}, c_DW'(axi.arready), 0);
        check({tag, "_awready"}, c_DW'(axi.awready), 0);
        check({tag, "_wready"}, c_DW'(axi.wready), 0);
        check({tag, "_rd_en"}, c_DW'(sram.read_en), 0);
        check({tag, "_wr_en"}, c_DW'(sram.write_en), 0);
        check({tag, "_rlast"}, c_DW'(axi.rlast), 0);
    endtask

    logic [c_DW-1:0] w4;
    logic [c_DW-1:0] e4;
    logic [c_DW-1:0] exp3 [0:3];
    logic [c_DW-1:0] exp6 [0:3];

    initial begin
        axi.awvalid = 0; axi.wvalid = 0; axi.bready = 0; axi.arvalid = 0; axi.rready = 0;
        axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
        axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
        axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0;

        // Preload every line while the bridge is held in reset.
        rst = 1'b1;
        tick();
        check_quiet("rst0");
        for (int i = 0; i < (1 << c_MAB); i++) bd_write(i, pat(i));
        rst = 1'b0;
        tick();
        check("idle_arready", c_DW'(axi.arready), 1);
        check("idle_awready", c_DW'(axi.awready), 1);

        // 1: reset in the middle of an INCR LEN=7 read
        ar_send(0, 8'd7, 2'b01, 4'd1);
        r_get("t1_b0", pat(0), 1'b0, 4'd1, 0);
        r_get("t1_b1", pat(1), 1'b0, 4'd1, 0);
        rst = 1'b1;
        tick();
        check_quiet("t1_rst");
        tick(); tick();
        rst = 1'b0;
        tick();
        ar_send(3, 8'd0, 2'b01, 4'd2);
        r_get("t1_new", pat(3), 1'b1, 4'd2, 0);

        // 2: INCR write LEN=3 at byte address 0x80 -> lines 1..4
        aw_send(1, 8'd3, 2'b01, 4'd5);
        for (int k = 0; k < 4; k++) w_send(wpat(k), '1, k == 3);
        b_get("t2_b", 2'b00, 4'd5);
        for (int k = 0; k < 4; k++) check($sformatf("t2_line%0d", k + 1), mem[k + 1], wpat(k));

        // 3: WRAP read LEN=3 at line 6 -> 6,7,4,5 (line 4 holds write data D)
        exp3[0] = pat(6); exp3[1] = pat(7); exp3[2] = wpat(3); exp3[3] = pat(5);
        ar_send(6, 8'd3, 2'b10, 4'd9);
        for (int k = 0; k < 4; k++)
            r_get($sformatf("t3_b%0d", k), exp3[k], k == 3, 4'd9, (k == 1) ? 5 : 0);

        // 4: single partial-strobe write to line 9 preloaded with all ones
        bd_write(9, '1);
        w4 = {32{32'h12345678}};
        w4[7:0] = 8'h5A;
        aw_send(9, 8'd0, 2'b01, 4'd3);
        w_send(w4, 128'h1, 1'b1);
`ifdef AXI4_LINE_EN_BRIDGE_RMW_EN
        e4 = {{(c_DW-8){1'b1}}, 8'h5A};
        b_get("t4_b", 2'b00, 4'd3);
`else
        e4 = '1;
        b_get("t4_b", 2'b10, 4'd3);
`endif
        check("t4_line9", mem[9], e4);

        // 5: simultaneous AR and AW, three times
        log_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            fork
                begin
                    ar_send(10, 8'd0, 2'b01, 4'd1);
                    r_get("t5_rd", pat(10), 1'b1, 4'd1, 0);
                end
                begin
                    aw_send(12, 8'd0, 2'b01, 4'd2);
                    w_send(wpat(40 + r), '1, 1'b1);
                    b_get("t5_b", 2'b00, 4'd2);
                end
            join
        end
        log_en = 1'b0;
        tick();
        check("t5_grants", c_DW'(gcnt), 6);
        check("t5_g0", c_DW'(glog[0]), 0);
        check("t5_g1", c_DW'(glog[1]), 1);
        check("t5_g2", c_DW'(glog[2]), 0);
        check("t5_g3", c_DW'(glog[3]), 1);
        check("t5_line12", mem[12], wpat(42));

        // 6: INCR read crossing the top of the array, then FIXED write
        exp6[0] = pat(1022); exp6[1] = pat(1023); exp6[2] = pat(0); exp6[3] = wpat(0);
        ar_send(1022, 8'd3, 2'b01, 4'd6);
        for (int k = 0; k < 4; k++) r_get($sformatf("t6_b%0d", k), exp6[k], k == 3, 4'd6, 0);
        aw_send(20, 8'd2, 2'b00, 4'd7);
        for (int k = 0; k < 3; k++) w_send(wpat(60 + k), '1, k == 2);
        b_get("t6_b", 2'b00, 4'd7);
        check("t6_line20", mem[20], wpat(62));
        check("t6_line21", mem[21], pat(21));

        check("no_dual_enable", c_DW'(both_seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
